burst_io_ctrl: RTL
==================

# burst_io_ctrl

Parametrised AXI-style burst request controller for the decompressor datapath. It splits one compressed-source read stream and one decompressed-destination write stream into bursts that never cross a 4 KB boundary. It tracks outstanding write responses against a configurable limit and reports completion and sticky error status to the host-control layer. It sits between the job-start/length registers and the AXI read/write address channels.

## Interface
- ADDR_W, 64, address width of src/dst addresses and request addresses.
- LEN_W, 35, width of both length inputs (bytes).
- BEAT_BYTES, 64, bytes per data beat; power of 2, ≥ 8.
- MAX_BEATS, 64, max beats per burst; power of 2, ≤ 256, MAX_BEATS*BEAT_BYTES ≤ 4096.
- MAX_OUT_WR, 16, max write bursts acked on address channel but not yet responded; power of 2, ≥ 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  job start pulse; accepted only while idle=1.
- src_addr  in  ADDR_W  read base address, byte.
- dst_addr  in  ADDR_W  write base address, byte.
- rd_length  in  LEN_W  bytes to read.
- wr_length  in  LEN_W  bytes to write.
- rd_req  out  1  read burst request.
- rd_req_ack  in  1  read request accepted.
- rd_addr  out  ADDR_W  read burst address.
- rd_len  out  8  read beats minus one.
- wr_req  out  1  write burst request.
- wr_req_ack  in  1  write request accepted.
- wr_addr  out  ADDR_W  write burst address.
- wr_len  out  8  write beats minus one.
- bvalid  in  1  write response valid.
- bresp  in  2  write response code; nonzero = error.
- bready  out  1  write response ready.
- done_i  in  1  datapath finished.
- idle  out  1  no job active.
- done  out  1  all bursts issued, all responses received.
- error  out  1  sticky: nonzero bresp seen this job.

## Operation
- Address low log2(BEAT_BYTES) bits are treated as zero; length is rounded up to whole beats: beats = ceil(len/BEAT_BYTES).
- Each channel is one splitter. States: IDLE, CALC, REQ, FIN.
  - IDLE → CALC on accepted start; loads address and beat count.
  - CALC: if beats_left=0 → FIN. Otherwise burst = min(beats_left, MAX_BEATS, beats to next 4 KB boundary); drives addr and len=burst-1 and req=1 → REQ.
  - REQ: holds req/addr/len stable until ack. On ack, addr += burst*BEAT_BYTES and beats_left -= burst. If beats_left>0, the next burst is computed in the same cycle; req stays 1 with new addr/len next cycle. Otherwise req=0 → FIN.
  - FIN: holds until next start.
- Write splitter gate: req is not asserted (and held low after an ack) while out_cnt = MAX_OUT_WR. out_cnt +1 on wr_req_ack, −1 on bvalid&bready; both in one cycle leaves it unchanged.
- bready = 1 whenever idle=0.
- done = 1 when both splitters are in FIN and out_cnt = 0. It holds until next accepted start.
- error is set on bvalid&bready&(bresp≠0) and cleared on accepted start. done still asserts normally.
- idle: 1 after reset; 0 on accepted start; 1 when done&done_i.
- start while idle=0 is ignored.

## Timing
- Reset values: rd_req=0, wr_req=0, rd_addr=wr_addr=0, rd_len=wr_len=0, bready=0, idle=1, done=0, error=0, out_cnt=0.
- Reset mid-operation: all outputs take reset values on the cycle after rst_n sampled low. Outstanding bursts are abandoned.
- start sampled at cycle 0 → CALC at cycle 1 → first req=1 at cycle 2.
- With ack held high, one burst per cycle.
- Zero length on both channels: done=1 at cycle 3, no requests issued.
- done rises the cycle after the final condition becomes true.
- out_cnt width is log2(MAX_OUT_WR)+1; it never overflows and never underflows (bvalid while out_cnt=0 is ignored for counting).

## Structure
- Package burst_io_pkg:
  - BOUNDARY_BYTES=4096.
  - splitter state enum (IDLE, CALC, REQ, FIN).
  - function burst_beats(addr, beats_left).
- Sub-module burst_splitter (ADDR_W, LEN_W, BEAT_BYTES, MAX_BEATS, plus an input gate `hold`). Instantiated twice: read with hold=0, write with hold=(out_cnt=MAX_OUT_WR).
- Top holds out_cnt, done/idle/error logic.

## Test plan
- Short read: src 0x1000, rd_length 100, wr_length 0, ack next cycle → one rd_req, addr 0x1000, len 1; done after ack.
- Multi-burst, ack held high: src 0x0, rd_length 8192 → bursts at 0x0 and 0x1000, len 63 each, on consecutive cycles.
- 4 KB split: src 0x0F80, rd_length 256 → 0x0F80 len 1, then 0x1000 len 1.
- Outstanding limit: MAX_OUT_WR=2, wr_length 16384, acks immediate, no bvalid → wr_req low after 2 acks. One bvalid → exactly one more burst. done only after 4 responses.
- Error path: one response bresp=2'b10 → error=1 at the next cycle, done still 1 at end. Next start clears error.
- Degenerate/reset: both lengths 0 → done at cycle 3, no req. rst_n low during REQ → rd_req=wr_req=0, idle=1 the following cycle.

Source files
------------

// File: rtl/burst_io_pkg.sv
// burst_io_pkg: shared constants, splitter state and burst sizing helper
package burst_io_pkg;

    localparam int BOUNDARY_BYTES = 4096;

    typedef enum logic [1:0] {IDLE, CALC, REQ, FIN} split_state_t;

    // Largest burst from addr_lo that respects the beat budget, the burst cap and the 4 KB page
    function automatic logic [8:0] burst_beats(
        input logic [11:0] addr_lo,
        input logic [63:0] beats_left,
        input int          beat_shift,
        input int          max_beats
    );
        logic [12:0] to_bound;
        logic [63:0] b;
        to_bound = (13'(BOUNDARY_BYTES) - {1'b0, addr_lo}) >> beat_shift;
        b = (beats_left < 64'(max_beats)) ? beats_left : 64'(max_beats);
        b = (b < {51'b0, to_bound}) ? b : {51'b0, to_bound};
        return b[8:0];
    endfunction

endpackage

// File: rtl/burst_splitter.sv
// burst_splitter: cuts one address/length job into 4 KB-safe request bursts
module burst_splitter
    import burst_io_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int LEN_W      = 35,
    parameter int BEAT_BYTES = 64,
    parameter int MAX_BEATS  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              hold,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              req,
    input  logic              ack,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        len,
    output logic              fin
);

    localparam int SH = $clog2(BEAT_BYTES);

    split_state_t      state;
    logic              req_r;
    logic              fire;
    logic [8:0]        burst;
    logic [8:0]        cur_b;
    logic [8:0]        nxt_b;
    logic [LEN_W-1:0]  beats_left;
    logic [LEN_W-1:0]  nxt_left;
    logic [LEN_W:0]    len_up;
    logic [ADDR_W-1:0] nxt_addr;

    assign len_up   = {1'b0, length} + (LEN_W+1)'(BEAT_BYTES - 1);
    assign req      = req_r & ~hold;
    assign fire     = req & ack;
    assign fin      = state == FIN;
    assign nxt_addr = addr + (ADDR_W'(burst) << SH);
    assign nxt_left = beats_left - LEN_W'(burst);
    assign cur_b    = burst_beats(addr[11:0], 64'(beats_left), SH, MAX_BEATS);
    assign nxt_b    = burst_beats(nxt_addr[11:0], 64'(nxt_left), SH, MAX_BEATS);

    // Splitter FSM: load job, size bursts, present each until acked, then park in FIN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_r      <= 1'b0;
            addr       <= '0;
            len        <= '0;
            burst      <= '0;
            beats_left <= '0;
        end else if (start) begin
            state      <= CALC;
            req_r      <= 1'b0;
            addr       <= base_addr & ~ADDR_W'(BEAT_BYTES - 1);
            beats_left <= LEN_W'(len_up >> SH);
        end else begin
            case (state)
                CALC: begin
                    if (beats_left == '0) begin
                        state <= FIN;
                    end else begin
                        burst <= cur_b;
                        len   <= 8'(cur_b - 9'd1);
                        req_r <= 1'b1;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (fire) begin
                        addr       <= nxt_addr;
                        beats_left <= nxt_left;
                        if (nxt_left == '0) begin
                            req_r <= 1'b0;
                            state <= FIN;
                        end else begin
                            burst <= nxt_b;
                            len   <= 8'(nxt_b - 9'd1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/burst_io_ctrl.sv
// burst_io_ctrl: read/write burst request control with outstanding-write limit and job status
module burst_io_ctrl
    import burst_io_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int LEN_W      = 35,
    parameter int BEAT_BYTES = 64,
    parameter int MAX_BEATS  = 64,
    parameter int MAX_OUT_WR = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  rd_length,
    input  logic [LEN_W-1:0]  wr_length,
    output logic              rd_req,
    input  logic              rd_req_ack,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_len,
    output logic              wr_req,
    input  logic              wr_req_ack,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_len,
    input  logic              bvalid,
    input  logic [1:0]        bresp,
    output logic              bready,
    input  logic              done_i,
    output logic              idle,
    output logic              done,
    output logic              error
);

    localparam int OC_W = $clog2(MAX_OUT_WR) + 1;

    logic [OC_W-1:0] out_cnt;
    logic            go;
    logic            full;
    logic            rd_fin;
    logic            wr_fin;
    logic            b_fire;
    logic            wr_fire;

    assign go      = start & idle;
    assign full    = out_cnt == OC_W'(MAX_OUT_WR);
    assign bready  = ~idle;
    assign b_fire  = bvalid & bready;
    assign wr_fire = wr_req & wr_req_ack;

    burst_splitter #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .BEAT_BYTES(BEAT_BYTES), .MAX_BEATS(MAX_BEATS)
    ) u_rd (
        .clk(clk), .rst_n(rst_n), .start(go), .hold(1'b0),
        .base_addr(src_addr), .length(rd_length),
        .req(rd_req), .ack(rd_req_ack), .addr(rd_addr), .len(rd_len), .fin(rd_fin)
    );

    burst_splitter #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .BEAT_BYTES(BEAT_BYTES), .MAX_BEATS(MAX_BEATS)
    ) u_wr (
        .clk(clk), .rst_n(rst_n), .start(go), .hold(full),
        .base_addr(dst_addr), .length(wr_length),
        .req(wr_req), .ack(wr_req_ack), .addr(wr_addr), .len(wr_len), .fin(wr_fin)
    );

    // Outstanding write bursts: up on address accept, down on a response that has something to retire
    always_ff @(posedge clk) begin
        out_cnt <= !rst_n ? '0 : out_cnt + OC_W'(wr_fire) - OC_W'(b_fire && out_cnt != '0);
    end

    // Job status: start clears, completion and errors stick until the next accepted start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle  <= 1'b1;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            idle  <= go ? 1'b0 : (idle | (done & done_i));
            done  <= go ? 1'b0 : (done | (rd_fin & wr_fin & (out_cnt == '0)));
            error <= go ? 1'b0 : (error | (b_fire & (|bresp)));
        end
    end

endmodule
